// File: rtl/serial_mag_cmp.sv
// Serial magnitude comparator: folds MSB-first 2-bit chunk compare flags
// into a full-width eq/gt/lt result, with sticky error on malformed chunks.
// Ports: clk, rst_n (async low); start; in_valid/in_ready chunk handshake
//        with aeb_i/agb_i/alb_i; busy, done, res_eq/gt/lt, err, chunk_cnt.
// Option: SERIAL_MAG_CMP_EARLY_EXIT_EN finishes on the first deciding chunk.
module serial_mag_cmp #(
    parameter int NCHUNK = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic                         aeb_i,
    input  logic                         agb_i,
    input  logic                         alb_i,
    output logic                         in_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         res_eq,
    output logic                         res_gt,
    output logic                         res_lt,
    output logic                         err,
    output logic [$clog2(NCHUNK+1)-1:0] chunk_cnt
);

    localparam int CW = $clog2(NCHUNK + 1);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          r_decided;
    logic          r_gt;
    logic          r_lt;
    logic          r_res_eq;
    logic          r_res_gt;
    logic          r_res_lt;

    logic w_accept;
    logic w_onehot;
    logic w_chunk_gt;
    logic w_chunk_lt;
    logic w_lock;
    logic w_last;
    logic w_finish;
    logic w_fin_gt;
    logic w_fin_lt;

    assign w_accept   = (r_state == S_RUN) & in_valid;
    // exactly one of three flags set
    assign w_onehot   = (aeb_i ^ agb_i ^ alb_i) & ~(aeb_i & agb_i & alb_i);
    // malformed chunks count as equal, so they never decide
    assign w_chunk_gt = w_accept & w_onehot & agb_i;
    assign w_chunk_lt = w_accept & w_onehot & alb_i;
    assign w_lock     = ~r_decided & (w_chunk_gt | w_chunk_lt);
    assign w_last     = w_accept & (r_cnt == LAST);
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
    assign w_finish   = w_last | w_lock;
`else
    assign w_finish   = w_last;
`endif
    // final result folds in the chunk being accepted on the finishing edge
    assign w_fin_gt   = r_decided ? r_gt : w_chunk_gt;
    assign w_fin_lt   = r_decided ? r_lt : w_chunk_lt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_finish) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == S_RUN);
        in_ready = (r_state == S_RUN);
        done     = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_res_eq  <= 1'b0;
            r_res_gt  <= 1'b0;
            r_res_lt  <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_res_eq  <= 1'b0;
            r_res_gt  <= 1'b0;
            r_res_lt  <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CW'(1);
            if (!w_onehot) r_err <= 1'b1;
            if (w_lock) begin
                r_decided <= 1'b1;
                r_gt      <= w_chunk_gt;
                r_lt      <= w_chunk_lt;
            end
            if (w_finish) begin
                r_res_eq <= ~(w_fin_gt | w_fin_lt);
                r_res_gt <= w_fin_gt;
                r_res_lt <= w_fin_lt;
            end
        end
    end

    assign res_eq    = r_res_eq;
    assign res_gt    = r_res_gt;
    assign res_lt    = r_res_lt;
    assign err       = r_err;
    assign chunk_cnt = r_cnt;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Testbench for serial_mag_cmp (NCHUNK=8): scoreboard of expected results
// pushed per compare and popped on each done pulse.
module tb_serial_mag_cmp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       aeb_i;
    logic       agb_i;
    logic       alb_i;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic       res_eq;
    logic       res_gt;
    logic       res_lt;
    logic       err;
    logic [3:0] chunk_cnt;

    typedef struct {
        logic [2:0] res;
        logic       err;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    serial_mag_cmp #(.NCHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .aeb_i     (aeb_i),
        .agb_i     (agb_i),
        .alb_i     (alb_i),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .res_eq    (res_eq),
        .res_gt    (res_gt),
        .res_lt    (res_lt),
        .err       (err),
        .chunk_cnt (chunk_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_extra_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res", {res_eq, res_gt, res_lt}, e.res);
                chk("err", err, e.err);
                chk("cnt", chunk_cnt, e.cnt);
            end
        end
    end

    task automatic run_cmp(input logic [15:0] a, input logic [15:0] b,
                           input bit tog, input int bad, input bit hold);
        exp_t       e;
        logic [2:0] fl[8];
        logic [1:0] ca;
        logic [1:0] cb;
        bit         dec;
        bit         g;
        bit         l;
        bit         acc;
        int         sent;
        int         cyc;
        e.err = 1'b0;
        e.cnt = 8;
        dec   = 0;
        g     = 0;
        l     = 0;
        for (int i = 0; i < 8; i++) begin
            ca = a[15-2*i -: 2];
            cb = b[15-2*i -: 2];
            if (i == bad) begin
                fl[i] = 3'b110;
                e.err = 1'b1;
            end else begin
                fl[i] = {ca == cb, ca > cb, ca < cb};
            end
            if (!dec && i != bad && ca != cb) begin
                dec = 1;
                g   = ca > cb;
                l   = ca < cb;
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
                e.cnt = i + 1;
                break;
`endif
            end
        end
        e.res = dec ? {1'b0, g, l} : 3'b100;
        sb.push_back(e);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        chk("start_busy", {busy, done, res_eq, res_gt, res_lt}, 5'b10000);
        chk("start_cnt", chunk_cnt, 0);
        chk("start_err", err, 0);
        sent = 0;
        cyc  = 0;
        while (sent < e.cnt && cyc < 64) begin
            if (tog && cyc[0]) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                {aeb_i, agb_i, alb_i} = fl[sent];
            end
            chk("rdy", in_ready, 1);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            cyc++;
            if (sent < e.cnt) begin
                chk("run", {busy, done, res_eq, res_gt, res_lt}, 5'b10000);
                chk("run_cnt", chunk_cnt, sent);
            end
        end
        in_valid = 1'b0;
        chk("lat", cyc, tog ? 2 * e.cnt - 1 : e.cnt);
        chk("done", {busy, done, in_ready}, 3'b010);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("idle", {busy, done}, 2'b00);
        chk("hold_res", {res_eq, res_gt, res_lt}, e.res);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        aeb_i    = 1'b0;
        agb_i    = 1'b0;
        alb_i    = 1'b0;
        #2;
        chk("rst_out", {busy, in_ready, done, res_eq, res_gt, res_lt, err},
            7'd0);
        chk("rst_cnt", chunk_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cmp(16'hABCD, 16'hABCD, 0, -1, 0);
        run_cmp(16'h8000, 16'h7FFF, 0, -1, 0);
        run_cmp(16'h1234, 16'h1235, 1, -1, 0);
        run_cmp(16'h5555, 16'h5555, 0, 3, 0);
        run_cmp(16'h5555, 16'h5555, 0, -1, 0);
        run_cmp(16'h00FF, 16'h0F00, 0, -1, 1);
        run_cmp(16'h3C00, 16'h3B00, 1, 6, 1);

        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b1;
        {aeb_i, agb_i, alb_i} = 3'b100;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_cnt", chunk_cnt, 4);
        rst_n = 1'b0;
        #1;
        chk("arst_out", {busy, in_ready, done, res_eq, res_gt, res_lt, err},
            7'd0);
        chk("arst_cnt", chunk_cnt, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("no_done", {busy, done}, 2'b00);
        end
        run_cmp(16'hF00F, 16'hF00E, 0, -1, 0);

        for (int i = 0; i < 4; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = (i == 1) ? ra : 16'($urandom);
            run_cmp(ra, rb, bit'($urandom_range(0, 1)),
                    (i == 2) ? int'($urandom_range(0, 7)) : -1, 0);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
